or1200_fetch_buf: RTL and testbench



---
 rtl/or1200_fetch_buf.sv | 128 ++++++++++++
 tb/tb_or1200_fetch_buf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_fetch_buf.sv
// Instruction fetch buffer: single-beat icpu reads queued with their PCs for decode.
// Optional OR1200_FETCHBUF_BYPASS_EN forwards a response straight to decode when the queue is empty.
module or1200_fetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INSN = 32'h1500_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic [31:0] icpu_adr_o,
  output logic        icpu_cycstb_o,
  input  logic        icpu_ack_i,
  input  logic        icpu_err_i,
  input  logic [31:0] icpu_dat_i,
  output logic [31:0] if_insn_o,
  output logic [31:0] if_pc_o,
  output logic        if_err_o,
  output logic        if_valid_o,
  input  logic        id_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        err;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   adr_r;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic   accept, resp, empty, push, pop, byp_vld;
  entry_t resp_entry, head;

  // Byte offset of the fetch address is meaningless for 32-bit instructions.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^pc_i[1:0];

  assign empty      = (count == '0);
  assign pc_ready_o = !rst && (state == IDLE) && (count < CNT_FULL) && !flush_i;
  assign accept     = pc_valid_i && pc_ready_o;
  assign resp       = (state == REQ) && (icpu_ack_i || icpu_err_i);

  // err wins when both terminations arrive together.
  assign resp_entry.insn = icpu_err_i ? NOP_INSN : icpu_dat_i;
  assign resp_entry.pc   = adr_r;
  assign resp_entry.err  = icpu_err_i;

`ifdef OR1200_FETCHBUF_BYPASS_EN
  assign byp_vld = resp && !flush_i && empty;
`else
  assign byp_vld = 1'b0;
`endif

  // A bypassed response consumed by decode never occupies a slot.
  assign push = resp && !flush_i && !(byp_vld && id_ready_i);
  assign pop  = !empty && id_ready_i && !flush_i;

  always_comb begin
    head = '0;
    if (!empty)       head = mem[rd_ptr];
    else if (byp_vld) head = resp_entry;
  end

  assign if_valid_o = !empty || byp_vld;
  assign if_insn_o  = head.insn;
  assign if_pc_o    = head.pc;
  assign if_err_o   = head.err;

  assign icpu_cycstb_o = (state != IDLE);
  assign icpu_adr_o    = adr_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ: begin
        if (icpu_ack_i || icpu_err_i) state_nxt = IDLE;
        else if (flush_i)             state_nxt = DROP;
      end
      // Bus cannot be abandoned mid-cycle; wait out the response and discard it.
      DROP:    if (icpu_ack_i || icpu_err_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      adr_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) adr_r <= {pc_i[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= resp_entry;
  end

endmodule

// File: tb/tb_or1200_fetch_buf.sv
// Scoreboard bench for or1200_fetch_buf: stimulus queues expected entries, a monitor checks decode output.
module tb_or1200_fetch_buf;

  localparam logic [31:0] NOP = 32'h1500_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0, flush_i = 1'b0;
  logic [31:0] icpu_adr_o;
  logic        icpu_cycstb_o, pc_ready_o;
  logic        icpu_ack_i = 1'b0, icpu_err_i = 1'b0;
  logic [31:0] icpu_dat_i = '0;
  logic [31:0] if_insn_o, if_pc_o;
  logic        if_err_o, if_valid_o;
  logic        id_ready_i = 1'b0;

  or1200_fetch_buf dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .flush_i(flush_i), .icpu_adr_o(icpu_adr_o), .icpu_cycstb_o(icpu_cycstb_o),
    .icpu_ack_i(icpu_ack_i), .icpu_err_i(icpu_err_i), .icpu_dat_i(icpu_dat_i),
    .if_insn_o(if_insn_o), .if_pc_o(if_pc_o), .if_err_o(if_err_o), .if_valid_o(if_valid_o),
    .id_ready_i(id_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flush and reset throw away everything queued or in flight, so the model does too.
  always @(negedge clk) begin
    if (rst || flush_i) sb.delete();
    else if (if_valid_o && id_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got pc %h insn %h expected no entry", if_pc_o, if_insn_o);
      end else begin
        mon_e = sb.pop_front();
        chk("out_insn", if_insn_o, mon_e.insn);
        chk("out_pc", if_pc_o, mon_e.pc);
        chk("out_err", {31'b0, if_err_o}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input logic [31:0] dat,
                       input logic a, input logic e, input int wait_cyc);
    int n = 0;
    while (!pc_ready_o && n < 20) begin tick(); n++; end
    if (!pc_ready_o) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got pc_ready 0 expected 1 within 20 cycles");
    end
    pc_i = pc;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    repeat (wait_cyc) tick();
    icpu_ack_i = a;
    icpu_err_i = e;
    icpu_dat_i = dat;
    sb.push_back('{insn: e ? NOP : dat, pc: {pc[31:2], 2'b00}, err: e});
    @(negedge clk);
    chk("req_stb", {31'b0, icpu_cycstb_o}, 32'd1);
    chk("req_adr", icpu_adr_o, {pc[31:2], 2'b00});
    tick();
    icpu_ack_i = 1'b0;
    icpu_err_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    id_ready_i = 1'b1;
    while (sb.size() > 0 && n < 20) begin tick(); n++; end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_stb", {31'b0, icpu_cycstb_o}, 32'd0);
    chk("rst_adr", icpu_adr_o, 32'd0);
    chk("rst_pc_ready", {31'b0, pc_ready_o}, 32'd0);
    chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
    chk("rst_insn", if_insn_o, 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_err", {31'b0, if_err_o}, 32'd0);
    tick();
    rst = 1'b0;
    id_ready_i = 1'b1;
    tick();

    // Single fetch latency
    pc_i = 32'h100;
    pc_valid_i = 1'b1;
    @(negedge clk);
    chk("t1_pc_ready", {31'b0, pc_ready_o}, 32'd1);
    tick();
    pc_valid_i = 1'b0;
    icpu_ack_i = 1'b1;
    icpu_dat_i = 32'hA0B0C0D0;
    sb.push_back('{insn: 32'hA0B0C0D0, pc: 32'h100, err: 1'b0});
    @(negedge clk);
    chk("t1_stb", {31'b0, icpu_cycstb_o}, 32'd1);
    chk("t1_adr", icpu_adr_o, 32'h100);
`ifdef OR1200_FETCHBUF_BYPASS_EN
    chk("t1_valid_ack_cycle", {31'b0, if_valid_o}, 32'd1);
`else
    chk("t1_valid_ack_cycle", {31'b0, if_valid_o}, 32'd0);
`endif
    tick();
    icpu_ack_i = 1'b0;
    @(negedge clk);
`ifdef OR1200_FETCHBUF_BYPASS_EN
    chk("t1_valid_after", {31'b0, if_valid_o}, 32'd0);
`else
    chk("t1_valid_after", {31'b0, if_valid_o}, 32'd1);
`endif
    chk("t1_pc_ready_after", {31'b0, pc_ready_o}, 32'd1);
    drain();

    // Fill to full, pop one, refill across the pointer wrap
    id_ready_i = 1'b0;
    fetch(32'h201, 32'h11110000, 1'b1, 1'b0, 0);
    fetch(32'h204, 32'h11110004, 1'b1, 1'b0, 0);
    fetch(32'h208, 32'h11110008, 1'b1, 1'b0, 1);
    fetch(32'h20C, 32'h1111000C, 1'b1, 1'b0, 0);
    chk("t2_full_pc_ready", {31'b0, pc_ready_o}, 32'd0);
    chk("t2_head_pc", if_pc_o, 32'h200);
    chk("t2_head_insn", if_insn_o, 32'h11110000);
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
    chk("t2_pop_pc_ready", {31'b0, pc_ready_o}, 32'd1);
    fetch(32'h210, 32'h11110010, 1'b1, 1'b0, 1);
    chk("t2_refull_pc_ready", {31'b0, pc_ready_o}, 32'd0);
    drain();
    tick();
    chk("t2_empty_valid", {31'b0, if_valid_o}, 32'd0);

    // Flush while a request is outstanding
    pc_i = 32'h400;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    chk("t3_flush_pc_ready", {31'b0, pc_ready_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    chk("t3_drop_stb", {31'b0, icpu_cycstb_o}, 32'd1);
    tick();
    icpu_ack_i = 1'b1;
    icpu_dat_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("t3_drop_ack_pc_ready", {31'b0, pc_ready_o}, 32'd0);
    tick();
    icpu_ack_i = 1'b0;
    @(negedge clk);
    chk("t3_after_pc_ready", {31'b0, pc_ready_o}, 32'd1);
    chk("t3_after_stb", {31'b0, icpu_cycstb_o}, 32'd0);
    chk("t3_after_valid", {31'b0, if_valid_o}, 32'd0);
    repeat (2) tick();

    // Flush coincident with ack, two entries queued
    id_ready_i = 1'b0;
    fetch(32'h500, 32'h22220000, 1'b1, 1'b0, 0);
    fetch(32'h504, 32'h22220004, 1'b1, 1'b0, 0);
    pc_i = 32'h508;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    icpu_ack_i = 1'b1;
    icpu_dat_i = 32'hBAD0BAD0;
    flush_i = 1'b1;
    @(negedge clk);
    chk("t4_flush_pc_ready", {31'b0, pc_ready_o}, 32'd0);
    tick();
    icpu_ack_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    chk("t4_valid", {31'b0, if_valid_o}, 32'd0);
    chk("t4_insn", if_insn_o, 32'd0);
    chk("t4_pc", if_pc_o, 32'd0);
    chk("t4_stb", {31'b0, icpu_cycstb_o}, 32'd0);
    chk("t4_pc_ready", {31'b0, pc_ready_o}, 32'd1);
    id_ready_i = 1'b1;
    repeat (3) tick();

    // Bus errors, including ack and err together
    fetch(32'h300, 32'h12345678, 1'b0, 1'b1, 0);
    fetch(32'h304, 32'h55555555, 1'b1, 1'b1, 1);
    fetch(32'h308, 32'h33330008, 1'b1, 1'b0, 0);
    drain();

    // Asynchronous reset mid-request, stray ack afterwards
    pc_i = 32'h600;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    chk("t6_stb_before", {31'b0, icpu_cycstb_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_stb_async", {31'b0, icpu_cycstb_o}, 32'd0);
    chk("t6_adr_async", icpu_adr_o, 32'd0);
    chk("t6_pc_ready_rst", {31'b0, pc_ready_o}, 32'd0);
    chk("t6_valid_rst", {31'b0, if_valid_o}, 32'd0);
    tick();
    rst = 1'b0;
    icpu_ack_i = 1'b1;
    icpu_dat_i = 32'h77777777;
    @(negedge clk);
    chk("t6_stray_stb", {31'b0, icpu_cycstb_o}, 32'd0);
    tick();
    icpu_ack_i = 1'b0;
    @(negedge clk);
    chk("t6_stray_valid", {31'b0, if_valid_o}, 32'd0);
    chk("t6_pc_ready", {31'b0, pc_ready_o}, 32'd1);

    // Recovery after reset
    fetch(32'h700, 32'h44440000, 1'b1, 1'b0, 2);
    drain();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
